trg_run_ctrl: RTL and testbench

//  Run/calibration sequencer for the minimum-trigger datapath. Drives EXEC_STATE and BASELINE into the per-channel

---
 rtl/trg_pkg.sv | 30 +++
 rtl/trg_baseline_accum.sv | 54 +++++
 rtl/trg_run_ctrl.sv | 152 +++++++++++++++
 tb/tb_trg_run_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trg_pkg.sv
// Shared definitions for the minimum-trigger datapath: EXEC_STATE codes, sample geometry,
// lane extraction and the run-sequencer state type. Used by the trigger block and trg_run_ctrl.
`ifndef TRG_LANE
`define TRG_LANE(data, idx, width) data[(idx)*16+15 -: (width)]
`endif

package trg_pkg;
    localparam int ADC_RESOLUTION_WIDTH = 12;
    localparam int S_AXIS_TDATA_WIDTH   = 128;
    localparam int SAMPLE_PER_TDATA     = S_AXIS_TDATA_WIDTH / 16;
    localparam int TIME_STAMP_WIDTH     = 16;
    localparam int LOG2_CALIB_WORDS     = 4;
    localparam int DRAIN_TIMEOUT        = 256;

    localparam logic [1:0] EXEC_INIT = 2'b00;
    localparam logic [1:0] EXEC_TRG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALIB = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } run_state_e;

    // Sample carried in the top bits of 16-bit lane idx.
    function automatic logic [ADC_RESOLUTION_WIDTH-1:0] lane_sample(
        input logic [S_AXIS_TDATA_WIDTH-1:0] data, input int idx);
        return `TRG_LANE(data, idx, ADC_RESOLUTION_WIDTH);
    endfunction
endpackage

// File: rtl/trg_baseline_accum.sv
// Baseline calibration accumulator: sums every lane of each accepted word, counts 2^N words,
// and presents the rounded-down average alongside a done strobe on the final word.
module trg_baseline_accum #(
    parameter int ADC_W      = trg_pkg::ADC_RESOLUTION_WIDTH,
    parameter int DATA_W     = trg_pkg::S_AXIS_TDATA_WIDTH,
    parameter int LOG2_WORDS = trg_pkg::LOG2_CALIB_WORDS
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic              i_tvalid,
    output logic              o_done,
    output logic [ADC_W-1:0]  o_average
);
    import trg_pkg::*;

    localparam int LANES     = DATA_W / 16;
    localparam int LANE_LOG2 = $clog2(LANES);
    localparam int ACC_W     = ADC_W + LANE_LOG2 + LOG2_WORDS;

    logic [ACC_W-1:0]      w_word_sum;
    logic [ACC_W-1:0]      w_acc_next;
    logic [ACC_W-1:0]      r_acc;
    logic [LOG2_WORDS-1:0] r_word_cnt;
    logic                  w_accept;

    always_comb begin
        w_word_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_word_sum = w_word_sum + ACC_W'(`TRG_LANE(i_tdata, i, ADC_W));
        end
    end

    assign w_accept   = i_enable & i_tvalid;
    assign w_acc_next = r_acc + w_word_sum;
    assign o_done     = w_accept & (r_word_cnt == '1);
    // Including the current word lets the top latch the average on the same edge as the last accept.
    assign o_average  = ADC_W'(w_acc_next >> (LANE_LOG2 + LOG2_WORDS));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc      <= '0;
            r_word_cnt <= '0;
        end else if (i_clear) begin
            r_acc      <= '0;
            r_word_cnt <= '0;
        end else if (w_accept) begin
            r_acc      <= w_acc_next;
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/trg_run_ctrl.sv
// Run/calibration sequencer: IDLE -> CALIB -> RUN -> DRAIN -> IDLE, driving EXEC_STATE and BASELINE.
// Optional TRG_EVENT_COUNT_EN adds O_EVENT_COUNT (rising edges of I_START_TRG while running).
module trg_run_ctrl #(
    parameter int ADC_RESOLUTION_WIDTH = trg_pkg::ADC_RESOLUTION_WIDTH,
    parameter int S_AXIS_TDATA_WIDTH   = trg_pkg::S_AXIS_TDATA_WIDTH,
    parameter int TIME_STAMP_WIDTH     = trg_pkg::TIME_STAMP_WIDTH,
    parameter int LOG2_CALIB_WORDS     = trg_pkg::LOG2_CALIB_WORDS,
    parameter int DRAIN_TIMEOUT        = trg_pkg::DRAIN_TIMEOUT
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESETN,
    input  logic                            START_CMD,
    input  logic                            STOP_CMD,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                            S_AXIS_TVALID,
    input  logic [TIME_STAMP_WIDTH-1:0]     CURRENT_TIME,
    input  logic                            I_START_TRG,
    input  logic                            I_FINALIZE_TRG,
    output logic [1:0]                      EXEC_STATE,
    output logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
    output logic                            BASELINE_VALID,
    output logic                            RUN_ACTIVE,
    output logic [TIME_STAMP_WIDTH-1:0]     O_RUN_START_TIME,
    output logic                            O_DRAIN_TIMEOUT,
`ifdef TRG_EVENT_COUNT_EN
    output logic [31:0]                     O_EVENT_COUNT,
`endif
    output trg_pkg::run_state_e             o_dbg_state
);
    import trg_pkg::*;

    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT);

    run_state_e                      r_state;
    run_state_e                      w_state_next;
    logic                            w_clear_accum;
    logic                            w_calib_done;
    logic                            w_capture;
    logic                            w_drain_expire;
    logic [ADC_RESOLUTION_WIDTH-1:0] w_average;
    logic [DRAIN_W-1:0]              r_drain_cnt;
    logic [1:0]                      r_exec_state;
    logic [ADC_RESOLUTION_WIDTH-1:0] r_baseline;
    logic                            r_baseline_valid;
    logic                            r_run_active;
    logic [TIME_STAMP_WIDTH-1:0]     r_run_start_time;
    logic                            r_drain_timeout;

    trg_baseline_accum #(
        .ADC_W      (ADC_RESOLUTION_WIDTH),
        .DATA_W     (S_AXIS_TDATA_WIDTH),
        .LOG2_WORDS (LOG2_CALIB_WORDS)
    ) u_accum (
        .i_clk     (AXIS_ACLK),
        .i_rst_n   (AXIS_ARESETN),
        .i_clear   (w_clear_accum),
        .i_enable  (r_state == ST_CALIB),
        .i_tdata   (S_AXIS_TDATA),
        .i_tvalid  (S_AXIS_TVALID),
        .o_done    (w_calib_done),
        .o_average (w_average)
    );

    always_comb begin
        w_state_next   = r_state;
        w_clear_accum  = 1'b0;
        w_capture      = 1'b0;
        w_drain_expire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START_CMD && !STOP_CMD) begin
                    w_state_next  = ST_CALIB;
                    w_clear_accum = 1'b1;
                end
            end
            ST_CALIB: begin
                if (STOP_CMD) begin
                    w_state_next = ST_IDLE;
                end else if (w_calib_done) begin
                    w_state_next = ST_RUN;
                    w_capture    = 1'b1;
                end
            end
            ST_RUN: begin
                if (STOP_CMD) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Trigger block is idle once neither a start nor a finalize is in flight.
                if (!I_START_TRG && !I_FINALIZE_TRG) begin
                    w_state_next = ST_IDLE;
                end else if (r_drain_cnt == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
                    w_state_next   = ST_IDLE;
                    w_drain_expire = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_state          <= ST_IDLE;
            r_drain_cnt      <= '0;
            r_exec_state     <= EXEC_INIT;
            r_baseline       <= '0;
            r_baseline_valid <= 1'b0;
            r_run_active     <= 1'b0;
            r_run_start_time <= '0;
            r_drain_timeout  <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_drain_cnt     <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;
            r_exec_state    <= (w_state_next == ST_RUN || w_state_next == ST_DRAIN) ? EXEC_TRG : EXEC_INIT;
            r_run_active    <= (w_state_next == ST_RUN || w_state_next == ST_DRAIN);
            r_drain_timeout <= w_drain_expire;
            if (w_capture) begin
                r_baseline       <= w_average;
                r_baseline_valid <= 1'b1;
                r_run_start_time <= CURRENT_TIME;
            end
        end
    end

`ifdef TRG_EVENT_COUNT_EN
    logic        r_start_trg_d;
    logic [31:0] r_event_cnt;

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_start_trg_d <= 1'b0;
            r_event_cnt   <= '0;
        end else begin
            r_start_trg_d <= I_START_TRG;
            if (w_clear_accum) begin
                r_event_cnt <= '0;
            end else if (r_run_active && I_START_TRG && !r_start_trg_d && (r_event_cnt != '1)) begin
                r_event_cnt <= r_event_cnt + 1'b1;
            end
        end
    end

    assign O_EVENT_COUNT = r_event_cnt;
`endif

    assign EXEC_STATE       = r_exec_state;
    assign BASELINE         = r_baseline;
    assign BASELINE_VALID   = r_baseline_valid;
    assign RUN_ACTIVE       = r_run_active;
    assign O_RUN_START_TIME = r_run_start_time;
    assign O_DRAIN_TIMEOUT  = r_drain_timeout;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_trg_run_ctrl.sv
// Self-checking bench for trg_run_ctrl: randomized calibration data against an averaging model,
// run/abort/drain/timeout scenarios and asynchronous reset.
module tb_trg_run_ctrl;
    import trg_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         START_CMD = 1'b0;
    logic         STOP_CMD = 1'b0;
    logic [127:0] S_AXIS_TDATA = '0;
    logic         S_AXIS_TVALID = 1'b0;
    logic [15:0]  CURRENT_TIME = '0;
    logic         I_START_TRG = 1'b0;
    logic         I_FINALIZE_TRG = 1'b0;
    logic [1:0]   EXEC_STATE;
    logic [11:0]  BASELINE;
    logic         BASELINE_VALID;
    logic         RUN_ACTIVE;
    logic [15:0]  O_RUN_START_TIME;
    logic         O_DRAIN_TIMEOUT;
    run_state_e   dbg_state;
`ifdef TRG_EVENT_COUNT_EN
    logic [31:0]  event_count;
`endif

    int           n_checks = 0;
    int           n_errors = 0;
    logic [11:0]  exp_q[$];
    logic [11:0]  last_baseline = '0;
    logic [15:0]  last_start_time = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    trg_run_ctrl dut (
        .AXIS_ACLK        (clk),
        .AXIS_ARESETN     (rst_n),
        .START_CMD        (START_CMD),
        .STOP_CMD         (STOP_CMD),
        .S_AXIS_TDATA     (S_AXIS_TDATA),
        .S_AXIS_TVALID    (S_AXIS_TVALID),
        .CURRENT_TIME     (CURRENT_TIME),
        .I_START_TRG      (I_START_TRG),
        .I_FINALIZE_TRG   (I_FINALIZE_TRG),
        .EXEC_STATE       (EXEC_STATE),
        .BASELINE         (BASELINE),
        .BASELINE_VALID   (BASELINE_VALID),
        .RUN_ACTIVE       (RUN_ACTIVE),
        .O_RUN_START_TIME (O_RUN_START_TIME),
        .O_DRAIN_TIMEOUT  (O_DRAIN_TIMEOUT),
`ifdef TRG_EVENT_COUNT_EN
        .O_EVENT_COUNT    (event_count),
`endif
        .o_dbg_state      (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_exec"}, 32'(EXEC_STATE), 32'(EXEC_INIT));
        check_val({tag, "_baseline"}, 32'(BASELINE), 0);
        check_val({tag, "_valid"}, 32'(BASELINE_VALID), 0);
        check_val({tag, "_active"}, 32'(RUN_ACTIVE), 0);
        check_val({tag, "_time"}, 32'(O_RUN_START_TIME), 0);
        check_val({tag, "_timeout"}, 32'(O_DRAIN_TIMEOUT), 0);
    endtask

    // ---------------- model helpers ----------------
    function automatic logic [31:0] word_sum(input logic [127:0] d);
        logic [31:0] s = 0;
        logic [15:0] lane;
        for (int i = 0; i < 8; i++) begin
            lane = d[16*i +: 16];
            s += 32'(lane[15:4]);
        end
        return s;
    endfunction

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        START_CMD = 1'b1;
        tick();
        START_CMD = 1'b0;
    endtask

    // mode 0: all lanes 0x0640 every cycle; 1: alternating 0/0xFFF0 lanes, random gaps; 2: random data and gaps.
    task automatic run_calib(input int mode);
        int          valid_words = 0;
        logic [31:0] total = 0;
        logic [127:0] d;
        logic        v;
        logic [15:0] t_last = '0;
        while (valid_words < 16) begin
            v = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            d = rand_word();
            if (v && mode != 2) begin
                for (int i = 0; i < 8; i++)
                    d[16*i +: 16] = (mode == 0) ? 16'h0640 : ((i % 2 == 1) ? 16'hFFF0 : 16'h0000);
            end
            if (v && valid_words == 15) begin
                check_val("calib_pending_exec", 32'(EXEC_STATE), 32'(EXEC_INIT));
                check_val("calib_pending_active", 32'(RUN_ACTIVE), 0);
            end
            CURRENT_TIME  = 16'($urandom);
            t_last        = CURRENT_TIME;
            S_AXIS_TVALID = v;
            S_AXIS_TDATA  = d;
            tick();
            if (v) begin
                valid_words++;
                total += word_sum(d);
            end
        end
        S_AXIS_TVALID = 1'b0;
        exp_q.push_back(12'(total / 128));
        last_baseline   = exp_q[$];
        last_start_time = t_last;
        check_val("calib_baseline", 32'(BASELINE), 32'(exp_q.pop_front()));
        check_val("calib_valid", 32'(BASELINE_VALID), 1);
        check_val("calib_exec", 32'(EXEC_STATE), 32'(EXEC_TRG));
        check_val("calib_active", 32'(RUN_ACTIVE), 1);
        check_val("calib_start_time", 32'(O_RUN_START_TIME), 32'(t_last));
    endtask

    task automatic stop_run();
        STOP_CMD = 1'b1;
        tick();
        STOP_CMD = 1'b0;
        check_val("drain_exec", 32'(EXEC_STATE), 32'(EXEC_TRG));
        check_val("drain_active", 32'(RUN_ACTIVE), 1);
        tick();
        check_val("stop_exec", 32'(EXEC_STATE), 32'(EXEC_INIT));
        check_val("stop_active", 32'(RUN_ACTIVE), 0);
        check_val("stop_timeout", 32'(O_DRAIN_TIMEOUT), 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int n;
        int pulses;
        int pulse_at;

        repeat (3) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Constant lanes of 0x0640 average to 100.
        pulse_start();
        run_calib(0);
        check_val("t1_baseline_100", 32'(BASELINE), 100);
        stop_run();

        // Abort on the 8th calibration word keeps the previous baseline.
        pulse_start();
        S_AXIS_TVALID = 1'b1;
        for (int i = 0; i < 8; i++) begin
            S_AXIS_TDATA = rand_word();
            if (i == 7) STOP_CMD = 1'b1;
            tick();
        end
        STOP_CMD = 1'b0;
        check_val("abort_exec", 32'(EXEC_STATE), 32'(EXEC_INIT));
        check_val("abort_baseline", 32'(BASELINE), 100);
        check_val("abort_valid", 32'(BASELINE_VALID), 1);
        repeat (20) begin
            S_AXIS_TDATA = rand_word();
            tick();
        end
        S_AXIS_TVALID = 1'b0;
        check_val("idle_ignores_data", 32'(EXEC_STATE), 32'(EXEC_INIT));

        // Alternating full-scale/zero lanes with gaps: 4*4095*16/128 = 2047.
        pulse_start();
        run_calib(1);
        check_val("t2_baseline_2047", 32'(BASELINE), 2047);
        pulse_start();
        tick();
        check_val("run_ignores_start_exec", 32'(EXEC_STATE), 32'(EXEC_TRG));
        check_val("run_ignores_start_bl", 32'(BASELINE), 32'(last_baseline));
        check_val("run_ignores_start_time", 32'(O_RUN_START_TIME), 32'(last_start_time));

        // Drain held by FINALIZE for 20 cycles.
        I_FINALIZE_TRG = 1'b1;
        STOP_CMD = 1'b1;
        tick();
        STOP_CMD = 1'b0;
        pulses = 0;
        for (int i = 0; i < 19; i++) begin
            if (EXEC_STATE != EXEC_TRG || O_DRAIN_TIMEOUT) pulses++;
            tick();
        end
        check_val("fin_hold_exec_bad_cycles", 32'(pulses), 0);
        check_val("fin_hold_exec", 32'(EXEC_STATE), 32'(EXEC_TRG));
        I_FINALIZE_TRG = 1'b0;
        tick();
        check_val("fin_release_exec", 32'(EXEC_STATE), 32'(EXEC_INIT));
        check_val("fin_release_active", 32'(RUN_ACTIVE), 0);
        check_val("fin_release_timeout", 32'(O_DRAIN_TIMEOUT), 0);

        // Random data; calibration restarts from a clean accumulator.
        pulse_start();
        run_calib(2);

        // Drain timeout with I_START_TRG stuck high; START/STOP inside drain are ignored.
        I_START_TRG = 1'b1;
        STOP_CMD = 1'b1;
        tick();
        STOP_CMD = 1'b0;
        n = 0;
        pulses = 0;
        pulse_at = -1;
        while (EXEC_STATE == EXEC_TRG && n < 400) begin
            if (n == 100) STOP_CMD = 1'b1;
            if (n == 150) START_CMD = 1'b1;
            tick();
            STOP_CMD = 1'b0;
            START_CMD = 1'b0;
            n++;
            if (O_DRAIN_TIMEOUT) begin
                pulses++;
                pulse_at = n;
            end
        end
        check_val("timeout_drain_cycles", 32'(n), 256);
        check_val("timeout_pulse_at_exit", 32'(pulse_at), 256);
        repeat (3) begin
            tick();
            if (O_DRAIN_TIMEOUT) pulses++;
        end
        check_val("timeout_pulse_count", 32'(pulses), 1);
        check_val("timeout_exit_active", 32'(RUN_ACTIVE), 0);
        check_val("timeout_keeps_baseline", 32'(BASELINE), 32'(last_baseline));
        I_START_TRG = 1'b0;
        tick();

`ifdef TRG_EVENT_COUNT_EN
        pulse_start();
        check_val("evt_cleared", event_count, 0);
        run_calib(2);
        tick();
        for (int i = 0; i < 5; i++) begin
            I_START_TRG = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            I_START_TRG = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        check_val("evt_count_5", event_count, 5);
        stop_run();
        check_val("evt_held_idle", event_count, 5);
`endif

        // START and STOP together in IDLE: STOP wins.
        START_CMD = 1'b1;
        STOP_CMD = 1'b1;
        tick();
        START_CMD = 1'b0;
        STOP_CMD = 1'b0;
        S_AXIS_TVALID = 1'b1;
        repeat (20) begin
            S_AXIS_TDATA = rand_word();
            tick();
        end
        S_AXIS_TVALID = 1'b0;
        check_val("start_stop_exec", 32'(EXEC_STATE), 32'(EXEC_INIT));
        check_val("start_stop_active", 32'(RUN_ACTIVE), 0);
        check_val("start_stop_baseline", 32'(BASELINE), 32'(last_baseline));

        // Asynchronous reset in the middle of calibration.
        pulse_start();
        S_AXIS_TVALID = 1'b1;
        repeat (5) begin
            S_AXIS_TDATA = rand_word();
            tick();
        end
        S_AXIS_TVALID = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset_vals("post_reset");

        pulse_start();
        run_calib(2);
        stop_run();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
